scene_radiance_recovery: RTL and testbench

Recovers the haze-free pixel J = (I − A)·tx_inv + A per colour channel. It is the consumer of the inverse transmission produced by the transmission map estimator. Raw centre pixels arrive earlier than their tx_inv values, so the block buffers pixels in a small FIFO and pairs each arriving tx_inv with the oldest buffered pixel. It then runs a 3-stage arithmetic pipeline with output backpressure, and feeds the output pixel writer.

---
 rtl/haze_pkg.sv | 13 +
 rtl/scene_radiance_recovery_if.sv | 32 +++
 rtl/scene_radiance_recovery_pix_fifo.sv | 52 +++++
 rtl/scene_radiance_recovery.sv | 133 +++++++++++++
 tb/tb_scene_radiance_recovery.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/haze_pkg.sv
// Shared widths and pixel type for the haze-removal datapath.
package haze_pkg;
  localparam int PIX_W   = 24;
  localparam int CH_W    = 8;
  localparam int TX_W    = 12;
  localparam int TX_FRAC = 8;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;
endpackage

// File: rtl/scene_radiance_recovery_if.sv
// Pixel, tx and output streams of scene_radiance_recovery, plus its status outputs.
interface scene_radiance_recovery_if;
  import haze_pkg::*;

  // Handshake: a transfer happens on a rising clk edge where valid && ready are both high.
  // pix_valid and tx_valid do not wait for ready; out_pix holds steady while out_ready is low.
  logic             pix_valid;
  logic [PIX_W-1:0] pix;
  logic             pix_ready;
  logic             tx_valid;
  logic [TX_W-1:0]  tx_inv;
  logic             tx_ready;
  logic [CH_W-1:0]  Ar;
  logic [CH_W-1:0]  Ag;
  logic [CH_W-1:0]  Ab;
  logic             out_valid;
  logic [PIX_W-1:0] out_pix;
  logic             out_ready;
  logic             ovf_err;
  logic             unf_err;
  logic [15:0]      out_count;

  modport master (
    output pix_valid, pix, tx_valid, tx_inv, Ar, Ag, Ab, out_ready,
    input  pix_ready, tx_ready, out_valid, out_pix, ovf_err, unf_err, out_count
  );

  modport slave (
    input  pix_valid, pix, tx_valid, tx_inv, Ar, Ag, Ab, out_ready,
    output pix_ready, tx_ready, out_valid, out_pix, ovf_err, unf_err, out_count
  );
endinterface

// File: rtl/scene_radiance_recovery_pix_fifo.sv
// Raw-pixel FIFO with count-based full/empty; the head is read combinationally.
module pix_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
endmodule

// File: rtl/scene_radiance_recovery.sv
// Haze-free pixel recovery J = (I - A) * tx_inv + A, pairing each tx with the oldest buffered pixel.
module scene_radiance_recovery
  import haze_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int FRAC  = TX_FRAC
) (
  input logic                      clk,
  input logic                      rst_n,
  scene_radiance_recovery_if.slave bus
);
  localparam logic signed [20:0] RND = 21'(2 ** (FRAC - 1));

  logic             fifo_full, fifo_empty, push, pop, stall;
  logic [PIX_W-1:0] fifo_dout;

  logic                  s1_v_q, s1_v_d, s2_v_q, s2_v_d, out_valid_q, out_valid_d;
  logic [2:0][CH_W-1:0]  s1_pix_q, s1_pix_d, s1_a_q, s1_a_d, s2_a_q, s2_a_d;
  logic [TX_W-1:0]       s1_tx_q, s1_tx_d;
  logic [2:0][12:0]      s2_r_q, s2_r_d, r_calc;
  logic [2:0][CH_W-1:0]  out_pix_q, out_pix_d, clamp_calc;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic [15:0]           out_count_q, out_count_d;

  function automatic logic [CH_W-1:0] clamp_u8(input logic signed [13:0] v);
    if (v < 0)              return '0;
    else if (v > 14'sd255)  return 8'hFF;
    else                    return v[CH_W-1:0];
  endfunction

  assign stall = out_valid_q && !bus.out_ready;
  // An empty FIFO never pops, even if a pixel is being pushed in the same cycle.
  assign pop   = bus.tx_valid && !stall && !fifo_empty;
  assign push  = bus.pix_valid && (!fifo_full || pop);

  pix_fifo #(.DEPTH(DEPTH), .W(PIX_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (bus.pix),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Per-channel arithmetic: S1->S2 difference, product and rounding; S2->S3 re-add and clamp.
  always_comb begin
    logic signed [8:0]  d;
    logic signed [20:0] p;
    logic signed [20:0] sh;
    logic signed [13:0] s;
    r_calc     = '0;
    clamp_calc = '0;
    for (int c = 0; c < 3; c++) begin
      d  = $signed({1'b0, s1_pix_q[c]}) - $signed({1'b0, s1_a_q[c]});
      p  = $signed({{12{d[8]}}, d}) * $signed({{(21-TX_W){1'b0}}, s1_tx_q});
      sh = (p + RND) >>> FRAC;
      r_calc[c] = sh[12:0];
      s  = $signed({s2_r_q[c][12], s2_r_q[c]}) + $signed({6'b0, s2_a_q[c]});
      clamp_calc[c] = clamp_u8(s);
    end
  end

  always_comb begin
    s1_v_d      = s1_v_q;
    s1_pix_d    = s1_pix_q;
    s1_a_d      = s1_a_q;
    s1_tx_d     = s1_tx_q;
    s2_v_d      = s2_v_q;
    s2_r_d      = s2_r_q;
    s2_a_d      = s2_a_q;
    out_valid_d = out_valid_q;
    out_pix_d   = out_pix_q;
    if (!stall) begin
      s1_v_d = pop;
      if (pop) begin
        s1_pix_d = fifo_dout;
        s1_a_d   = {bus.Ar, bus.Ag, bus.Ab};
        s1_tx_d  = bus.tx_inv;
      end
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_r_d = r_calc;
        s2_a_d = s1_a_q;
      end
      out_valid_d = s2_v_q;
      if (s2_v_q) out_pix_d = clamp_calc;
    end
    ovf_d       = ovf_q || (bus.pix_valid && fifo_full && !pop);
    unf_d       = unf_q || (bus.tx_valid && !stall && fifo_empty);
    out_count_d = out_count_q;
    if (out_valid_q && bus.out_ready) out_count_d = out_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q      <= 1'b0;
      s1_pix_q    <= '0;
      s1_a_q      <= '0;
      s1_tx_q     <= '0;
      s2_v_q      <= 1'b0;
      s2_r_q      <= '0;
      s2_a_q      <= '0;
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      out_count_q <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_pix_q    <= s1_pix_d;
      s1_a_q      <= s1_a_d;
      s1_tx_q     <= s1_tx_d;
      s2_v_q      <= s2_v_d;
      s2_r_q      <= s2_r_d;
      s2_a_q      <= s2_a_d;
      out_valid_q <= out_valid_d;
      out_pix_q   <= out_pix_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      out_count_q <= out_count_d;
    end
  end

  assign bus.pix_ready = !fifo_full;
  assign bus.tx_ready  = !stall;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pix   = out_pix_q;
  assign bus.ovf_err   = ovf_q;
  assign bus.unf_err   = unf_q;
  assign bus.out_count = out_count_q;
endmodule

// File: tb/tb_scene_radiance_recovery.sv
// Directed and randomized checks of scene_radiance_recovery against a per-cycle reference model.
module tb_scene_radiance_recovery;
  localparam int DEPTH = 4;
  localparam int FRAC  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  scene_radiance_recovery_if bus();

  scene_radiance_recovery #(.DEPTH(DEPTH), .FRAC(FRAC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [23:0] ref_pix(input logic [23:0] p, input logic [23:0] a, input int tx);
    logic [23:0] res;
    int i_c, a_c, num, r, s;
    res = '0;
    for (int c = 0; c < 3; c++) begin
      i_c = int'(p[c*8 +: 8]);
      a_c = int'(a[c*8 +: 8]);
      num = (i_c - a_c) * tx + (1 << (FRAC - 1));
      r   = num / (1 << FRAC);
      if (num < 0 && (num % (1 << FRAC)) != 0) r = r - 1;
      s = r + a_c;
      if (s < 0) s = 0;
      else if (s > 255) s = 255;
      res[c*8 +: 8] = s[7:0];
    end
    return res;
  endfunction

  logic [23:0] pq[$];
  logic [23:0] exp_q[$];
  logic [2:0]  pv;
  logic [15:0] m_cnt;
  logic        m_ovf, m_unf, m_stall, m_pop, m_push;
  logic [23:0] m_head;

  always @(negedge clk) begin
    if (!rst_n) begin
      pq.delete();
      exp_q.delete();
      pv    = '0;
      m_cnt = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_stall = pv[2] && !bus.out_ready;
      chk(bus.out_valid, pv[2], "out_valid");
      if (pv[2]) chk(bus.out_pix, (exp_q.size() > 0) ? exp_q[0] : 24'hx, "out_pix");
      chk(bus.pix_ready, pq.size() < DEPTH, "pix_ready");
      chk(bus.tx_ready, !m_stall, "tx_ready");
      chk(bus.ovf_err, m_ovf, "ovf_err");
      chk(bus.unf_err, m_unf, "unf_err");
      chk(bus.out_count, m_cnt, "out_count");
      m_pop = bus.tx_valid && !m_stall && (pq.size() > 0);
      if (bus.tx_valid && !m_stall && pq.size() == 0) m_unf = 1'b1;
      if (m_pop) begin
        m_head = pq.pop_front();
        exp_q.push_back(ref_pix(m_head, {bus.Ar, bus.Ag, bus.Ab}, int'(bus.tx_inv)));
      end
      m_push = bus.pix_valid && (pq.size() < DEPTH);
      if (bus.pix_valid && !m_push) m_ovf = 1'b1;
      if (m_push) pq.push_back(bus.pix);
      if (pv[2] && bus.out_ready) begin
        m_cnt = m_cnt + 16'd1;
        void'(exp_q.pop_front());
      end
      if (!m_stall) pv = {pv[1:0], m_pop};
    end
  end

  // ---------------- driver tasks ----------------
  int exp_cnt;
  int hist[64];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.pix_valid = 1'b0;
    bus.pix       = '0;
    bus.tx_valid  = 1'b0;
    bus.tx_inv    = '0;
    bus.Ar        = '0;
    bus.Ag        = '0;
    bus.Ab        = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic run_one(input logic [23:0] p, input logic [7:0] a, input logic [11:0] tx,
                         input logic [23:0] expv, input string tag);
    bus.pix_valid = 1'b1;
    bus.pix       = p;
    tick();
    bus.pix_valid = 1'b0;
    bus.tx_valid  = 1'b1;
    bus.tx_inv    = tx;
    {bus.Ar, bus.Ag, bus.Ab} = {a, a, a};
    tick();
    bus.tx_valid = 1'b0;
    tick();
    chk(bus.out_valid, 1'b0, {tag, "_early"});
    tick();
    chk(bus.out_valid, 1'b1, {tag, "_valid"});
    chk(bus.out_pix, expv, {tag, "_pix"});
    tick();
    exp_cnt++;
    chk(bus.out_count, exp_cnt, {tag, "_count"});
  endtask

  // Pixels every cycle; each tx follows its accepted pixel by two cycles and waits for tx_ready.
  task automatic stream(input int n_pix, input int stall_lo, input int stall_hi,
                        input int cycles, input bit pix_pause, output int n_tx);
    int k, n_ok, lag;
    bit stalled;
    k = 0; n_ok = 0; n_tx = 0;
    for (int c = 0; c < cycles; c++) begin
      stalled       = (c >= stall_lo) && (c < stall_hi);
      bus.out_ready = !stalled;
      bus.pix_valid = (k < n_pix) && !(pix_pause && stalled);
      bus.pix       = 24'($urandom);
      lag           = (c >= 2) ? hist[c-2] : 0;
      bus.tx_valid  = (n_tx < lag);
      bus.tx_inv    = 12'($urandom_range(0, 12'h2ff));
      {bus.Ar, bus.Ag, bus.Ab} = 24'($urandom);
      #1;
      if (bus.pix_valid) k++;
      if (bus.pix_valid && bus.pix_ready) n_ok++;
      hist[c] = n_ok;
      if (bus.tx_valid && bus.tx_ready) n_tx++;
      if (c == stall_lo + 1) begin
        chk(bus.tx_ready, 1'b0, "bp_tx_ready");
        chk(bus.out_valid, 1'b1, "bp_out_valid");
      end
      tick();
    end
    idle();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 30; i++) begin
      if (pv == 3'b000 && exp_q.size() == 0) break;
      tick();
    end
    chk(exp_q.size(), 0, tag);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n_tx;
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk(bus.out_valid, 1'b0, "rst_out_valid");
    chk(bus.out_pix, 24'h0, "rst_out_pix");
    chk(bus.pix_ready, 1'b1, "rst_pix_ready");
    chk(bus.tx_ready, 1'b1, "rst_tx_ready");
    chk({bus.ovf_err, bus.unf_err}, 2'b00, "rst_flags");
    chk(bus.out_count, 16'h0, "rst_count");
    rst_n = 1'b1;
    exp_cnt = 0;
    tick();

    run_one(24'hC89664, 8'd220, 12'h100, 24'hC89664, "identity");
    run_one(24'hC89664, 8'd220, 12'h200, 24'hB45000, "scale_clamp");
    run_one(24'hFF0000, 8'd10,  12'h180, 24'hFF0000, "upper_clamp");

    stream(8, 100, 100, 10, 1'b0, n_tx);
    drain("lag_drain");
    exp_cnt += 8;
    chk(bus.out_count, exp_cnt, "lag_count");
    chk({bus.ovf_err, bus.unf_err}, 2'b00, "lag_flags");

    stream(10, 5, 8, 16, 1'b1, n_tx);
    drain("bp_drain");
    exp_cnt += 10;
    chk(bus.out_count, exp_cnt, "bp_count");
    chk(bus.ovf_err, 1'b0, "bp_no_ovf");

    stream(12, 5, 11, 22, 1'b0, n_tx);
    drain("ovf_drain");
    chk(bus.ovf_err, 1'b1, "ovf_flag");
    chk(bus.out_count, exp_cnt + n_tx, "ovf_count");
    chk(n_tx < 12, 1'b1, "ovf_missing");

    stream(2, 100, 100, 4, 1'b0, n_tx);
    #2 rst_n = 1'b0;
    #1;
    chk(bus.out_valid, 1'b0, "arst_out_valid");
    chk(bus.out_pix, 24'h0, "arst_out_pix");
    chk(bus.pix_ready, 1'b1, "arst_pix_ready");
    chk(bus.tx_ready, 1'b1, "arst_tx_ready");
    chk({bus.ovf_err, bus.unf_err}, 2'b00, "arst_flags");
    chk(bus.out_count, 16'h0, "arst_count");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk(bus.out_valid, 1'b0, "arst_no_output");
    end

    bus.tx_valid = 1'b1;
    bus.tx_inv   = 12'h100;
    tick();
    bus.tx_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk(bus.out_valid, 1'b0, "unf_no_output");
      tick();
    end
    chk(bus.unf_err, 1'b1, "unf_flag");
    chk(bus.out_count, 16'h0, "unf_count");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
